// File: rtl/lsu_mem_master.sv
// Load/store unit master: takes one pipeline request at a time, checks alignment,
// strobes the data memory, waits out its stall handshake and returns a one-cycle response.
module lsu_mem_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mask,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_memread,
    output logic        mem_memwrite,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [CW-1:0]   tmo_cnt;
    logic            mem_we;
    logic            rd_q;
    logic            wr_q;
    logic            size_ok;
    logic            misalign;
    logic            tmo_hit;

    assign size_ok  = (req_mask[2:0] == 3'b001) || (req_mask[2:0] == 3'b010) ||
                      (req_mask[2:0] == 3'b100);
    assign misalign = !size_ok || (req_mask[1] && req_addr[0]) ||
                      (req_mask[2] && (req_addr[1:0] != 2'b00));
    assign tmo_hit  = (tmo_cnt == TMO_LIMIT);

    // The strobe is withdrawn as soon as the memory reports busy, so it never sees a second start.
    assign mem_memread  = rd_q && !mem_clk_stall;
    assign mem_memwrite = wr_q && !mem_clk_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            tmo_cnt        <= '0;
            mem_we         <= 1'b0;
            rd_q           <= 1'b0;
            wr_q           <= 1'b0;
            req_ready      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_sign_mask  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        mem_addr       <= req_addr;
                        mem_write_data <= req_wdata;
                        mem_sign_mask  <= req_mask;
                        mem_we         <= req_we;
                        tmo_cnt        <= '0;
                        req_ready      <= 1'b0;
                        if (misalign) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state <= ISSUE;
                            rd_q  <= !req_we;
                            wr_q  <= req_we;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    if (mem_clk_stall) begin
                        state <= WAIT;
                        rd_q  <= 1'b0;
                        wr_q  <= 1'b0;
                    end else if (tmo_hit) begin
                        state      <= RESP;
                        rd_q       <= 1'b0;
                        wr_q       <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    // A completing memory wins over a timeout landing in the same cycle.
                    if (!mem_clk_stall) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= mem_we ? 32'h0 : mem_read_data;
                    end else if (tmo_hit) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
